calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Keyboard-driven sequencer for the two-operand decimal calculator datapath. It consumes debounced one-pulse key events from the PS/2 decode/validate chain, collects operand A, an operator and operand B, and runs a multi-cycle shift-add multiply and a double-dabble BCD conversion. It drives four BCD digit codes into the `segment7`/`display_7seg` path. It replaces the simple add-only controller in the calculator top level.

## Interface
- `KEY_BITS`, 9: width of the key scan code (`last_change` format, bit 8 = extended flag).
- `BLANK`, 4'hF: digit code that the 7-seg decoder renders as all-off.
- `MINUS`, 4'hE: digit code that the 7-seg decoder renders as segment g only.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `kb_in`  in  KEY_BITS  scan code of the last pressed key; sampled only when `key_valid`=1.
- `key_valid`  in  1  one-cycle press pulse.
- `d3`,`d2`,`d1`,`d0`  out  4 each  display digit codes, `d3` leftmost.
- `state`  out  3  FSM state: S_A=0, S_B=1, S_CALC=2, S_CONV=3, S_SHOW=4.
- `op`  out  2  latched operator: 0=add, 1=sub, 2=mul.
- `busy`  out  1  high in S_CALC and S_CONV.
- `done`  out  1  one-cycle pulse on the first S_SHOW cycle.

## Operation
- Key map. All codes have bit 8 = 0.
  - Digits 0–9: 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46.
  - Operators: '+' = 0x79, '-' = 0x7B, '*' = 0x7C.
  - Enter = 0x5A. Esc = 0x76.
  - Any other code is ignored.
- Operand registers: a1:a0 and b1:b0, BCD, 0–99.
- Digit entry shifts: x1←x0, x0←new. A third digit drops the oldest, so 1,2,3 gives 23.
- S_A
  - Digit updates A.
  - Operator latches `op`, clears B, goes to S_B.
  - Enter is ignored.
- S_B
  - Digit updates B.
  - Enter goes to S_CALC.
  - Operator is ignored.
- S_CALC (fixed 7 cycles, all ops)
  - Convert A and B to binary: 7 bits each.
  - mul: 7-step shift-add into a 14-bit product.
  - add: A+B. sub: |A−B|, with `neg`=(A<B).
  - add/sub results are loaded on the first cycle and held for the remaining cycles.
  - Then go to S_CONV.
- S_CONV (fixed 14 cycles): double-dabble the 14-bit result into 4 BCD nibbles. Then go to S_SHOW.
- S_SHOW
  - A digit key clears A and B, loads the digit into a0, sets `op`=0 and goes to S_A.
  - Operators and Enter are ignored.
- Esc in any state goes to S_A in the next cycle. It clears A, B, `op` and `neg`, and aborts any computation; `done` does not fire.
- Keys arriving in S_CALC or S_CONV are ignored, except Esc.
- Display, registered, updated in the cycle after the causing event:
  - S_A: BLANK, BLANK, a1, a0.
  - S_B: BLANK, BLANK, b1, b0.
  - S_CALC/S_CONV: display held.
  - S_SHOW, positive: BCD result with leading zeros blanked; d0 is never blanked.
  - S_SHOW, `neg`: d3=MINUS, magnitude in d1:d0, d2=BLANK, d1 blanked if zero.
- Result ranges: add 0–198, sub −99..99, mul 0–9801; all fit 4 digits.

## Timing
- Reset values:
  - `state`=S_A, A=B=0, `op`=0.
  - d3=d2=BLANK, d1=d0=0.
  - `busy`=0, `done`=0.
- A key is accepted on the edge where `key_valid`=1.
- Enter accepted at edge k:
  - `state`=S_CALC for 7 cycles, after edges k..k+6.
  - `state`=S_CONV for 14 cycles, after edges k+7..k+20.
  - `state`=S_SHOW after edge k+21, with `done`=1 for that one cycle and digits valid.
- Enter to result latency: 22 cycles.
- `busy` equals (`state`==S_CALC || `state`==S_CONV).
- Asserting `rst` mid-operation immediately forces the reset values. No partial result is ever displayed.
- `key_valid` on two consecutive cycles: each pulse is processed independently.

## Test plan
- Reset, then keys 4,2,+,7,Enter:
  - `busy` for exactly 21 cycles.
  - `done` at Enter+22.
  - Display F,F,4,9.
- 9,9,*,9,9,Enter: display 9,8,0,1; `op`=2.
- 3,-,4,5,Enter: display E,F,4,2. Then 0,-,0,Enter: display F,F,F,0.
- 1,2,3 in S_A: display F,F,2,3. Then '-' goes to S_B with display F,F,0,0. Then Enter gives F,F,2,3.
- Esc pulsed during S_CONV:
  - Next cycle `state`=0, display F,F,0,0.
  - No `done`.
  - Digits and Enter pulsed during S_CALC have no effect.
- `rst` low mid-S_CALC: all outputs at reset values immediately; normal entry works after release.

Source files
------------

// File: rtl/calc_sequencer.sv
// Keyboard sequencer for the two-operand decimal calculator: collects A, op, B,
// computes add/sub/mul over a fixed 7-cycle window, then double-dabbles the result for display.
module calc_sequencer #(
  parameter int         KEY_BITS = 9,
  parameter logic [3:0] BLANK    = 4'hF,
  parameter logic [3:0] MINUS    = 4'hE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_BITS-1:0] kb_in,
  input  logic                key_valid,
  output logic [3:0]          d3,
  output logic [3:0]          d2,
  output logic [3:0]          d1,
  output logic [3:0]          d0,
  output logic [2:0]          state,
  output logic [1:0]          op,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_CALC = 3'd2,
    S_CONV = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  localparam logic [KEY_BITS-1:0] K_D0    = KEY_BITS'(9'h045);
  localparam logic [KEY_BITS-1:0] K_D1    = KEY_BITS'(9'h016);
  localparam logic [KEY_BITS-1:0] K_D2    = KEY_BITS'(9'h01E);
  localparam logic [KEY_BITS-1:0] K_D3    = KEY_BITS'(9'h026);
  localparam logic [KEY_BITS-1:0] K_D4    = KEY_BITS'(9'h025);
  localparam logic [KEY_BITS-1:0] K_D5    = KEY_BITS'(9'h02E);
  localparam logic [KEY_BITS-1:0] K_D6    = KEY_BITS'(9'h036);
  localparam logic [KEY_BITS-1:0] K_D7    = KEY_BITS'(9'h03D);
  localparam logic [KEY_BITS-1:0] K_D8    = KEY_BITS'(9'h03E);
  localparam logic [KEY_BITS-1:0] K_D9    = KEY_BITS'(9'h046);
  localparam logic [KEY_BITS-1:0] K_PLUS  = KEY_BITS'(9'h079);
  localparam logic [KEY_BITS-1:0] K_SUB   = KEY_BITS'(9'h07B);
  localparam logic [KEY_BITS-1:0] K_MUL   = KEY_BITS'(9'h07C);
  localparam logic [KEY_BITS-1:0] K_ENTER = KEY_BITS'(9'h05A);
  localparam logic [KEY_BITS-1:0] K_ESC   = KEY_BITS'(9'h076);

  state_t      state_q, state_d;
  logic [3:0]  a1_q, a1_d, a0_q, a0_d, b1_q, b1_d, b0_q, b0_d;
  logic [1:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] res_q, res_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  d3_q, d3_d, d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
  logic        done_q, done_d;

  logic        is_digit, is_op, is_enter, is_esc;
  logic [3:0]  digit;
  logic [1:0]  op_code;
  logic [6:0]  a_bin, b_bin, diff;
  logic [13:0] addend;
  logic [15:0] bcd_adj;
  logic        z3, z32, z321;

  assign a_bin  = {3'b0, a1_q} * 7'd10 + {3'b0, a0_q};
  assign b_bin  = {3'b0, b1_q} * 7'd10 + {3'b0, b0_q};
  assign diff   = (a_bin >= b_bin) ? a_bin - b_bin : b_bin - a_bin;
  assign addend = {7'd0, a_bin} << cnt_q;

  // Double-dabble pre-shift correction: any BCD nibble above 4 gets +3.
  for (genvar gi = 0; gi < 4; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] > 4'd4) ? bcd_q[gi*4 +: 4] + 4'd3
                                                           : bcd_q[gi*4 +: 4];
  end

  always_comb begin
    is_digit = 1'b0;
    is_op    = 1'b0;
    digit    = 4'd0;
    op_code  = 2'd0;
    is_enter = key_valid && (kb_in == K_ENTER);
    is_esc   = key_valid && (kb_in == K_ESC);
    if (key_valid) begin
      case (kb_in)
        K_D0:   begin is_digit = 1'b1; digit = 4'd0; end
        K_D1:   begin is_digit = 1'b1; digit = 4'd1; end
        K_D2:   begin is_digit = 1'b1; digit = 4'd2; end
        K_D3:   begin is_digit = 1'b1; digit = 4'd3; end
        K_D4:   begin is_digit = 1'b1; digit = 4'd4; end
        K_D5:   begin is_digit = 1'b1; digit = 4'd5; end
        K_D6:   begin is_digit = 1'b1; digit = 4'd6; end
        K_D7:   begin is_digit = 1'b1; digit = 4'd7; end
        K_D8:   begin is_digit = 1'b1; digit = 4'd8; end
        K_D9:   begin is_digit = 1'b1; digit = 4'd9; end
        K_PLUS: begin is_op = 1'b1; op_code = 2'd0; end
        K_SUB:  begin is_op = 1'b1; op_code = 2'd1; end
        K_MUL:  begin is_op = 1'b1; op_code = 2'd2; end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    a1_d = a1_q; a0_d = a0_q; b1_d = b1_q; b0_d = b0_q;
    op_d = op_q; neg_d = neg_q; cnt_d = cnt_q;
    res_d = res_q; bcd_d = bcd_q;
    d3_d = d3_q; d2_d = d2_q; d1_d = d1_q; d0_d = d0_q;
    z3 = 1'b0; z32 = 1'b0; z321 = 1'b0;

    case (state_q)
      S_A: begin
        if (is_digit) begin
          a1_d = a0_q; a0_d = digit;
        end else if (is_op) begin
          op_d = op_code; b1_d = 4'd0; b0_d = 4'd0; state_d = S_B;
        end
      end
      S_B: begin
        if (is_digit) begin
          b1_d = b0_q; b0_d = digit;
        end else if (is_enter) begin
          state_d = S_CALC; cnt_d = 4'd0; res_d = 14'd0; neg_d = 1'b0;
        end
      end
      S_CALC: begin
        if (op_q == 2'd2) begin
          if (b_bin[cnt_q[2:0]]) res_d = res_q + addend;
        end else if (cnt_q == 4'd0) begin
          res_d = (op_q == 2'd0) ? {7'd0, a_bin} + {7'd0, b_bin} : {7'd0, diff};
          neg_d = (op_q == 2'd1) && (a_bin < b_bin);
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd6) begin
          state_d = S_CONV; cnt_d = 4'd0; bcd_d = 16'd0;
        end
      end
      S_CONV: begin
        bcd_d = {bcd_adj[14:0], res_q[13]};
        res_d = {res_q[12:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) state_d = S_SHOW;
      end
      S_SHOW: begin
        if (is_digit) begin
          a1_d = 4'd0; a0_d = digit; b1_d = 4'd0; b0_d = 4'd0;
          op_d = 2'd0; state_d = S_A;
        end
      end
      default: state_d = S_A;
    endcase

    if (is_esc) begin
      state_d = S_A; cnt_d = 4'd0;
      a1_d = 4'd0; a0_d = 4'd0; b1_d = 4'd0; b0_d = 4'd0;
      op_d = 2'd0; neg_d = 1'b0;
    end

    // Display tracks the next state so it changes in the cycle right after the key.
    case (state_d)
      S_A: begin d3_d = BLANK; d2_d = BLANK; d1_d = a1_d; d0_d = a0_d; end
      S_B: begin d3_d = BLANK; d2_d = BLANK; d1_d = b1_d; d0_d = b0_d; end
      S_SHOW: begin
        if (state_q != S_SHOW) begin
          if (neg_d) begin
            d3_d = MINUS; d2_d = BLANK;
            d1_d = (bcd_d[7:4] == 4'd0) ? BLANK : bcd_d[7:4];
            d0_d = bcd_d[3:0];
          end else begin
            z3   = (bcd_d[15:12] == 4'd0);
            z32  = z3 && (bcd_d[11:8] == 4'd0);
            z321 = z32 && (bcd_d[7:4] == 4'd0);
            d3_d = z3   ? BLANK : bcd_d[15:12];
            d2_d = z32  ? BLANK : bcd_d[11:8];
            d1_d = z321 ? BLANK : bcd_d[7:4];
            d0_d = bcd_d[3:0];
          end
        end
      end
      default: ;
    endcase

    done_d = (state_d == S_SHOW) && (state_q != S_SHOW);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_A;
      a1_q <= 4'd0; a0_q <= 4'd0; b1_q <= 4'd0; b0_q <= 4'd0;
      op_q <= 2'd0; neg_q <= 1'b0; cnt_q <= 4'd0;
      res_q <= 14'd0; bcd_q <= 16'd0;
      d3_q <= BLANK; d2_q <= BLANK; d1_q <= 4'd0; d0_q <= 4'd0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a1_q <= a1_d; a0_q <= a0_d; b1_q <= b1_d; b0_q <= b0_d;
      op_q <= op_d; neg_q <= neg_d; cnt_q <= cnt_d;
      res_q <= res_d; bcd_q <= bcd_d;
      d3_q <= d3_d; d2_q <= d2_d; d1_q <= d1_d; d0_q <= d0_d;
      done_q <= done_d;
    end
  end

  assign state = state_q;
  assign op    = op_q;
  assign busy  = (state_q == S_CALC) || (state_q == S_CONV);
  assign done  = done_q;
  assign d3 = d3_q;
  assign d2 = d2_q;
  assign d1 = d1_q;
  assign d0 = d0_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Randomized bench for calc_sequencer against an integer-arithmetic calculator model.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [8:0] kb_in = 9'h000;
  logic       key_valid = 1'b0;
  logic [3:0] d3, d2, d1, d0;
  logic [2:0] state;
  logic [1:0] op;
  logic       busy, done;

  calc_sequencer dut (
    .clk(clk), .rst(rst), .kb_in(kb_in), .key_valid(key_valid),
    .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .state(state), .op(op), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [8:0] K_PLUS = 9'h079, K_SUB = 9'h07B, K_MUL = 9'h07C;
  localparam logic [8:0] K_ENT = 9'h05A, K_ESC = 9'h076;
  logic [8:0] DIG [10] = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025,
                           9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046};
  logic [8:0] JUNK [4] = '{9'h01C, 9'h15A, 9'h000, 9'h145};
  logic [8:0] OPS [3]  = '{K_PLUS, K_SUB, K_MUL};

  int checks = 0;
  int errors = 0;

  // Model: operands as integers, mode 0=enter A, 1=enter B, 4=showing result.
  int m_a = 0, m_b = 0, m_op = 0, m_st = 0;
  logic [15:0] m_disp = 16'hFF00;

  wire [15:0] disp = {d3, d2, d1, d0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] opnd_disp(input int x);
    return {4'hF, 4'hF, 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic logic [15:0] res_disp(input int r);
    logic [15:0] v;
    int dg[4];
    bit lead;
    int m;
    if (r < 0) begin
      m = -r;
      return {4'hE, 4'hF, (m / 10 == 0) ? 4'hF : 4'(m / 10), 4'(m % 10)};
    end
    dg[3] = r / 1000; dg[2] = (r / 100) % 10; dg[1] = (r / 10) % 10; dg[0] = r % 10;
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && dg[i] == 0) v[i*4 +: 4] = 4'hF;
      else begin lead = 1'b0; v[i*4 +: 4] = 4'(dg[i]); end
    end
    v[3:0] = 4'(dg[0]);
    return v;
  endfunction

  function automatic int digit_of(input logic [8:0] c);
    for (int i = 0; i < 10; i++) if (DIG[i] == c) return i;
    return -1;
  endfunction

  function automatic int op_of(input logic [8:0] c);
    for (int i = 0; i < 3; i++) if (OPS[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_a = 0; m_b = 0; m_op = 0; m_st = 0; m_disp = 16'hFF00;
  endtask

  task automatic model_key(input logic [8:0] c, output bit calc);
    int d, o;
    calc = 1'b0;
    d = digit_of(c);
    o = op_of(c);
    if (c == K_ESC) begin
      model_reset();
    end else if (m_st == 0) begin
      if (d >= 0) m_a = (m_a * 10 + d) % 100;
      else if (o >= 0) begin m_op = o; m_b = 0; m_st = 1; end
    end else if (m_st == 1) begin
      if (d >= 0) m_b = (m_b * 10 + d) % 100;
      else if (c == K_ENT) calc = 1'b1;
    end else if (m_st == 4) begin
      if (d >= 0) begin m_a = d; m_b = 0; m_op = 0; m_st = 0; end
    end
    if (m_st == 0) m_disp = opnd_disp(m_a);
    else if (m_st == 1) m_disp = opnd_disp(m_b);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, 32'(state), 32'(m_st));
    check({tag, "_op"}, 32'(op), 32'(m_op));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_disp"}, 32'(disp), 32'(m_disp));
  endtask

  // Called at the falling edge right after Enter was accepted.
  task automatic wait_result(input bit noise, input int esc_at);
    int r, n, seen;
    r = (m_op == 0) ? m_a + m_b : (m_op == 1) ? m_a - m_b : m_a * m_b;
    check("busy_start", 32'(busy), 32'd1);
    check("hold_disp", 32'(disp), 32'(m_disp));
    n = 0;
    while (busy && n < 40) begin
      check("done_early", 32'(done), 32'd0);
      n++;
      if (esc_at == n) begin
        kb_in = K_ESC; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        model_reset();
        check_idle("esc_abort");
        seen = 0;
        repeat (25) begin
          @(negedge clk);
          if (done || state != 3'd0) seen++;
        end
        check("esc_no_done", 32'(seen), 32'd0);
        return;
      end
      if (noise && n <= 5) begin
        kb_in = (n % 2 == 1) ? DIG[8] : K_ENT;
        key_valid = 1'b1;
      end else key_valid = 1'b0;
      @(negedge clk);
    end
    key_valid = 1'b0;
    check("busy_len", 32'(n), 32'd21);
    check("done_pulse", 32'(done), 32'd1);
    check("show_state", 32'(state), 32'd4);
    m_st = 4;
    m_disp = res_disp(r);
    check("result", 32'(disp), 32'(m_disp));
    $display("calc a=%0d b=%0d op=%0d -> %h", m_a, m_b, m_op, disp);
    @(negedge clk);
    check("done_drop", 32'(done), 32'd0);
  endtask

  // Called at a falling edge; returns at the falling edge after the key is taken.
  task automatic press(input logic [8:0] c, input bit noise = 1'b0, input int esc_at = 0);
    bit calc;
    kb_in = c; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    model_key(c, calc);
    if (calc) wait_result(noise, esc_at);
    else check_idle("key");
  endtask

  task automatic press_seq(input logic [8:0] s[$]);
    foreach (s[i]) press(s[i]);
  endtask

  initial begin
    int r, gap;
    logic [8:0] c;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    check_idle("reset");
    rst = 1'b1;
    @(negedge clk);

    press_seq('{DIG[4], DIG[2], K_PLUS, DIG[7], K_ENT});
    check("r49", 32'(disp), 32'hFF49);
    press_seq('{DIG[9], DIG[9], K_MUL, DIG[9], DIG[9], K_ENT});
    check("r9801", 32'(disp), 32'h9801);
    check("op_mul", 32'(op), 32'd2);
    press_seq('{DIG[3], K_SUB, DIG[4], DIG[5], K_ENT});
    check("rneg42", 32'(disp), 32'hEF42);
    press_seq('{DIG[0], K_SUB, DIG[0], K_ENT});
    check("rzero", 32'(disp), 32'hFFF0);
    press_seq('{DIG[1], DIG[2], DIG[3]});
    check("shift3", 32'(disp), 32'hFF23);
    press_seq('{K_SUB, K_PLUS, K_ENT});
    check("r23", 32'(disp), 32'hFF23);

    // Keys during CALC ignored; then an Esc during CONV.
    press_seq('{DIG[5], K_MUL, DIG[6]});
    press(K_ENT, 1'b1, 0);
    check("r30_noise", 32'(disp), 32'hFF30);
    press_seq('{DIG[7], K_PLUS, DIG[8]});
    press(K_ENT, 1'b1, 12);

    // Asynchronous reset in the middle of CALC.
    press_seq('{DIG[2], K_MUL, DIG[3]});
    kb_in = K_ENT; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    model_reset();
    check_idle("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    press_seq('{DIG[6], K_PLUS, DIG[6], K_ENT});
    check("after_rst", 32'(disp), 32'hFF12);

    for (int k = 0; k < 300; k++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 55) c = DIG[$urandom_range(0, 9)];
      else if (r < 67) c = OPS[$urandom_range(0, 2)];
      else if (r < 80) c = K_ENT;
      else if (r < 85) c = K_ESC;
      else if (r < 92) c = JUNK[$urandom_range(0, 3)];
      else c = DIG[$urandom_range(0, 9)];
      press(c, 1'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
